// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int PC_WIDTH   = 12;
  localparam int INSN_WIDTH = 32;

  localparam logic [PC_WIDTH-1:0] RESET_PC = '0;

  typedef logic [PC_WIDTH-1:0]   pc_t;
  typedef logic [INSN_WIDTH-1:0] insn_t;

  // One buffered fetch: the word and the address it came from.
  typedef struct packed {
    pc_t   pc;
    insn_t insn;
  } fetch_entry_t;

  // Sequential successor; wraps naturally at the top of the address space.
  function automatic pc_t pc_inc(input pc_t pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {pc, insn} entries. Flush empties it in one
// edge; push and pop may happen on the same edge without disturbing order.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_b_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output fetch_entry_t     head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next pointers and occupancy; a flush discards everything, including a
  // same-cycle pop (that word has already been taken by decode).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Storage and pointer registers; reset clears the entries so the head reads zero.
  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // The issue credit in the parent keeps a request from landing on a full buffer.
  a_no_push_when_full: assert property (
    @(posedge clk_i) disable iff (!rst_b_i)
      !(push_i && !flush_i && (count_q == CNT_W'(DEPTH))));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC and issue logic, one in-flight imem request,
// and a small buffer feeding decode over valid/ready. Redirects squash all
// younger work and restart fetch at the target.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [PC_WIDTH-1:0]   address_imem,
  input  logic [INSN_WIDTH-1:0] q_imem,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  dec_valid,
  input  logic                  dec_ready,
  output logic [INSN_WIDTH-1:0] dec_insn,
  output logic [PC_WIDTH-1:0]   dec_pc
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  pc_t              fetch_pc_q, fetch_pc_d;
  pc_t              req_pc_q, req_pc_d;
  logic             req_valid_q, req_valid_d;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic             pop, push, issue;
  fetch_entry_t     head, push_entry;

  assign pop  = dec_valid & dec_ready;
  assign push = req_valid_q & ~redirect_valid;

  // Words owed to decode after this edge: buffered plus in flight, less the
  // one leaving now. Issue only when that leaves room for another return.
  assign occupancy = (CNT_W+1)'(count) + (CNT_W+1)'(req_valid_q) - (CNT_W+1)'(pop);
  assign issue     = redirect_valid | (occupancy < (CNT_W+1)'(DEPTH));

  // Address is independent of dec_ready; when no issue happens it is simply re-read.
  assign address_imem = !reset         ? RESET_PC :
                        redirect_valid ? redirect_pc : fetch_pc_q;

  // Next state of the PC and the in-flight request.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    req_valid_d = issue;
    if (issue) begin
      req_pc_d   = address_imem;
      fetch_pc_d = pc_inc(address_imem);
    end
  end

  // PC and in-flight request registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
    end
  end

  assign push_entry = '{pc: req_pc_q, insn: q_imem};

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk_i       (clock),
    .rst_b_i     (reset),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (head)
  );

  assign dec_valid = (count != '0);
  assign dec_insn  = head.insn;
  assign dec_pc    = head.pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a behavioural imem, directed scenarios followed by
// random traffic, and a monitor that checks delivery order, latency and the
// fetch address against an in-order stream model.
module tb_fetch_stage;

  localparam int PCW = 12;

  logic            clock = 1'b0;
  logic            reset;
  logic [PCW-1:0]  address_imem;
  logic [31:0]     q_imem;
  logic            redirect_valid;
  logic [PCW-1:0]  redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [31:0]     dec_insn;
  logic [PCW-1:0]  dec_pc;

  logic [31:0]     mem [1 << PCW];
  logic [PCW-1:0]  seg_q [$];

  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage dut (
    .clock          (clock),
    .reset          (reset),
    .address_imem   (address_imem),
    .q_imem         (q_imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_insn       (dec_insn),
    .dec_pc         (dec_pc)
  );

  always #5 clock = ~clock;

  // Synchronous imem with one cycle of read latency.
  always @(posedge clock) q_imem <= mem[address_imem];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Stream model: each reset or redirect starts a new in-order segment. At
  // most two fetched-but-undelivered words exist per segment, so the address
  // presented at segment age a is start + min(a, delivered + 2); the head
  // becomes valid two cycles after the segment starts and then stays valid.
  int             age = 0;
  int             pops = 0;
  int             adv;
  logic [PCW-1:0] seg_start = '0;
  logic [PCW-1:0] nxt = '0;
  logic [PCW-1:0] tgt;
  logic           prev_rst_low = 1'b0;
  logic           was_pop;

  always @(negedge clock) begin
    if (!reset) begin
      chk("rst_addr", 32'(address_imem), 32'(0));
      if (prev_rst_low) begin
        chk("rst_valid", 32'(dec_valid), 32'(0));
        chk("rst_pc", 32'(dec_pc), 32'(0));
        chk("rst_insn", dec_insn, 32'(0));
      end
      if (redirect_valid && seg_q.size() > 0) void'(seg_q.pop_front());
      prev_rst_low = 1'b1;
      age = 0;
      pops = 0;
      seg_start = '0;
      nxt = '0;
    end else begin
      if (prev_rst_low) begin
        chk("rel_pc", 32'(dec_pc), 32'(0));
        chk("rel_insn", dec_insn, 32'(0));
      end
      prev_rst_low = 1'b0;
      chk("valid", 32'(dec_valid), 32'(age >= 2));
      if (redirect_valid) begin
        if (seg_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL redir_queue at %0t: got empty expected target", $time);
          tgt = redirect_pc;
        end else begin
          tgt = seg_q.pop_front();
        end
        chk("redir_addr", 32'(address_imem), 32'(tgt));
      end else begin
        adv = (age < pops + 2) ? age : pops + 2;
        chk("fetch_addr", 32'(address_imem), 32'(PCW'(seg_start + PCW'(adv))));
      end
      if (dec_valid && age >= 2) begin
        chk("head_pc", 32'(dec_pc), 32'(nxt));
        chk("head_insn", dec_insn, mem[nxt]);
      end
      was_pop = dec_valid && dec_ready;
      if (was_pop) nxt = nxt + 1'b1;
      if (redirect_valid) begin
        seg_start = tgt;
        nxt = tgt;
        age = 1;
        pops = 0;
      end else begin
        age++;
        if (was_pop) pops++;
      end
    end
  end

  task automatic cyc(input logic rst_n, input logic rdy, input logic redir,
                     input logic [PCW-1:0] target);
    reset          = rst_n;
    dec_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = target;
    if (redir && rst_n) seg_q.push_back(target);
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b1, rdy, 1'b0, '0);
  endtask

  logic           r_rst, r_rdy, r_redir;
  logic [PCW-1:0] r_tgt;

  initial begin
    for (int i = 0; i < (1 << PCW); i++) mem[i] = $urandom;
    reset = 1'b0; dec_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;

    // Reset, then stream
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, '0);
    run(8, 1'b1);
    // Stall from cycle 2 after a fresh reset, then release
    cyc(1'b0, 1'b1, 1'b0, '0);
    run(2, 1'b1);
    run(6, 1'b0);
    run(6, 1'b1);
    // Redirect in a steady stream
    cyc(1'b1, 1'b1, 1'b1, 12'h100);
    run(6, 1'b1);
    // Redirect near the top of the address space, wrapping to 0
    cyc(1'b1, 1'b1, 1'b1, 12'hFFF);
    run(6, 1'b1);
    // Redirect coinciding with a pop from a full buffer
    run(4, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 12'h200);
    run(6, 1'b1);
    // Back-to-back redirects
    cyc(1'b1, 1'b1, 1'b1, 12'h300);
    cyc(1'b1, 1'b0, 1'b1, 12'h400);
    run(6, 1'b1);
    // Reset mid-stream with a full buffer
    run(4, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    run(6, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r_rst   = ($urandom_range(0, 199) != 0);
      r_rdy   = ($urandom_range(0, 3) != 0);
      r_redir = r_rst && ($urandom_range(0, 15) == 0);
      r_tgt   = ($urandom_range(0, 3) == 0) ? PCW'(12'hFFD + PCW'($urandom_range(0, 2)))
                                            : PCW'($urandom);
      cyc(r_rst, r_rdy, r_redir, r_tgt);
    end
    run(4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
